stream_prefetcher: RTL and testbench



---
 rtl/prefetch_pkg.sv | 20 ++
 rtl/stream_prefetcher.sv | 174 +++++++++++++++++
 tb/tb_stream_prefetcher.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// Shared definitions for the stream prefetcher: FSM state encoding,
// default geometry constants and the line-offset helper.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } pf_state_e;

  localparam int DEFAULT_LINE_BYTES = 32;
  localparam int DEFAULT_PAGE_BYTES = 4096;

  // Number of byte-offset bits inside one cacheline.
  function automatic int offset_of(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/stream_prefetcher.sv
// Next-N-line prefetcher. A miss trigger opens a sequential stream of up to
// DEGREE line reads that never leaves the trigger's page. Each returned line
// is handed back to the cache over a valid/ready fill handshake. Triggers that
// land inside the running stream are filtered, and one further trigger can
// wait in a pending slot until the current stream finishes.
module stream_prefetcher
  import prefetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = DEFAULT_LINE_BYTES,
  parameter int LINE_W     = 256,
  parameter int WAY_W      = 1,
  parameter int DEGREE     = 2,
  parameter int PAGE_BYTES = DEFAULT_PAGE_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_valid,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [WAY_W-1:0]  trig_way,
  input  logic              flush,
  output logic              pf_read,
  output logic [ADDR_W-1:0] pf_address,
  input  logic [LINE_W-1:0] pf_rdata,
  input  logic              pf_resp,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [LINE_W-1:0] fill_data,
  output logic [ADDR_W-1:0] fill_address,
  output logic [WAY_W-1:0]  fill_way,
  output logic              busy
);

  localparam int OFFSET     = offset_of(LINE_BYTES);
  localparam int LN_W       = ADDR_W - OFFSET;
  localparam int PAGE_LINES = PAGE_BYTES / LINE_BYTES;

  // Lines still available after the given line inside its own page, capped at DEGREE.
  function automatic logic [3:0] stream_len(input logic [LN_W-1:0] line);
    logic [31:0] idx;
    logic [31:0] after;
    idx   = 32'(line) & 32'(PAGE_LINES - 1);
    after = 32'(PAGE_LINES - 1) - idx;
    if (after > 32'(DEGREE)) begin
      return 4'(DEGREE);
    end
    return 4'(after);
  endfunction

  pf_state_e         state;
  logic [LN_W-1:0]   cur_line;
  logic [LN_W-1:0]   base_line;
  logic [3:0]        remaining;
  logic [WAY_W-1:0]  way_q;

  logic              pend_valid;
  logic [LN_W-1:0]   pend_line;
  logic [WAY_W-1:0]  pend_way;

  logic [LINE_W-1:0] fill_data_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [WAY_W-1:0]  fill_way_q;

  logic [LN_W-1:0]   trig_line;
  logic [3:0]        trig_len;
  logic              trig_dup;
  logic              trig_ok;

  logic [LN_W-1:0]   start_line;
  logic [WAY_W-1:0]  start_way;
  logic [3:0]        start_len;
  logic              start_go;

  logic              unused_offset;

  assign unused_offset = ^trig_addr[OFFSET-1:0];

  // Qualify the incoming trigger: page-limited length and the duplicate
  // window [base_line, base_line+DEGREE] of the stream currently running.
  always_comb begin
    trig_line = trig_addr[ADDR_W-1:OFFSET];
    trig_len  = stream_len(trig_line);
    trig_dup  = (state != IDLE) && ((trig_line - base_line) <= LN_W'(DEGREE));
    trig_ok   = trig_valid && (trig_len != 4'd0) && !trig_dup;
  end

  // From IDLE a fresh trigger takes priority; it is newer than any pending one.
  always_comb begin
    start_line = pend_line;
    start_way  = pend_way;
    start_len  = stream_len(pend_line);
    start_go   = pend_valid;
    if (trig_ok) begin
      start_line = trig_line;
      start_way  = trig_way;
      start_len  = trig_len;
      start_go   = 1'b1;
    end
  end

  // Stream FSM, stream registers, pending slot and the captured fill line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_line    <= '0;
      base_line   <= '0;
      remaining   <= '0;
      way_q       <= '0;
      pend_valid  <= 1'b0;
      pend_line   <= '0;
      pend_way    <= '0;
      fill_data_q <= '0;
      fill_addr_q <= '0;
      fill_way_q  <= '0;
    end else if (flush) begin
      pend_valid <= 1'b0;
      remaining  <= '0;
      case (state)
        REQ:     state <= pf_resp ? IDLE : DRAIN;
        FILL:    state <= IDLE;
        DRAIN:   if (pf_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end else begin
      if (trig_ok && (state != IDLE)) begin
        pend_valid <= 1'b1;
        pend_line  <= trig_line;
        pend_way   <= trig_way;
      end
      case (state)
        IDLE: begin
          if (start_go) begin
            state      <= REQ;
            base_line  <= start_line;
            cur_line   <= start_line + LN_W'(1);
            remaining  <= start_len;
            way_q      <= start_way;
            pend_valid <= 1'b0;
          end
        end
        REQ: begin
          if (pf_resp) begin
            fill_data_q <= pf_rdata;
            fill_addr_q <= {cur_line, {OFFSET{1'b0}}};
            fill_way_q  <= way_q;
            cur_line    <= cur_line + LN_W'(1);
            remaining   <= remaining - 4'd1;
            state       <= FILL;
          end
        end
        FILL: begin
          if (fill_ready) begin
            state <= (remaining != 4'd0) ? REQ : IDLE;
          end
        end
        DRAIN: begin
          if (pf_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pf_read      = (state == REQ) || (state == DRAIN);
  assign pf_address   = pf_read ? {cur_line, {OFFSET{1'b0}}} : '0;
  assign fill_valid   = (state == FILL);
  assign fill_data    = fill_data_q;
  assign fill_address = fill_addr_q;
  assign fill_way     = fill_way_q;
  assign busy         = (state != IDLE) || pend_valid;

endmodule

// File: tb/tb_stream_prefetcher.sv
// Directed bench for stream_prefetcher with the default geometry
// (32-byte lines, 4 KiB pages, DEGREE=2). Expected reads and fills are queued
// when a trigger is issued and consumed as the DUT requests and delivers lines.
module tb_stream_prefetcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         trig_valid;
  logic [31:0]  trig_addr;
  logic [0:0]   trig_way;
  logic         flush;
  logic         pf_read;
  logic [31:0]  pf_address;
  logic [255:0] pf_rdata;
  logic         pf_resp;
  logic         fill_valid;
  logic         fill_ready;
  logic [255:0] fill_data;
  logic [31:0]  fill_address;
  logic [0:0]   fill_way;
  logic         busy;

  typedef struct {
    logic [31:0] addr;
    logic        way;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  stream_prefetcher dut (
    .clk          (clk),
    .rst          (rst),
    .trig_valid   (trig_valid),
    .trig_addr    (trig_addr),
    .trig_way     (trig_way),
    .flush        (flush),
    .pf_read      (pf_read),
    .pf_address   (pf_address),
    .pf_rdata     (pf_rdata),
    .pf_resp      (pf_resp),
    .fill_valid   (fill_valid),
    .fill_ready   (fill_ready),
    .fill_data    (fill_data),
    .fill_address (fill_address),
    .fill_way     (fill_way),
    .busy         (busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory model contents: every line address maps to a distinct pattern.
  function automatic logic [255:0] data_of(input logic [31:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) begin
      d[i*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic way);
    trig_valid = 1'b1;
    trig_addr  = addr;
    trig_way   = way;
    tick();
    trig_valid = 1'b0;
  endtask

  task automatic expect_stream(input logic [31:0] first, input logic way, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = first + 32'(i * 32);
      e.way  = way;
      exp_q.push_back(e);
    end
  endtask

  // Serve one memory read after the requested number of idle cycles, checking address stability.
  task automatic do_read(input int delay);
    int waited = 0;
    logic [31:0] exp_addr;
    while (pf_read !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("read_wait", 256'(pf_read), 256'(1'b1));
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL read_queue: observed=empty expected=entry");
      exp_addr = '0;
    end else begin
      exp_addr = exp_q[0].addr;
    end
    checkOutput("pf_address", 256'(pf_address), 256'(exp_addr));
    for (int i = 0; i < delay; i++) begin
      tick();
      checkOutput("pf_read_hold", 256'(pf_read), 256'(1'b1));
      checkOutput("pf_address_hold", 256'(pf_address), 256'(exp_addr));
    end
    pf_resp  = 1'b1;
    pf_rdata = data_of(pf_address);
    tick();
    pf_resp  = 1'b0;
    pf_rdata = '0;
    checkOutput("pf_read_drop", 256'(pf_read), 256'(1'b0));
    checkOutput("fill_valid_rise", 256'(fill_valid), 256'(1'b1));
  endtask

  // Accept one fill after the requested number of back-pressure cycles.
  task automatic do_fill(input int stall);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL fill_queue: observed=empty expected=entry");
      e.addr = '0;
      e.way  = 1'b0;
    end else begin
      e = exp_q.pop_front();
    end
    checkOutput("fill_address", 256'(fill_address), 256'(e.addr));
    checkOutput("fill_way", 256'(fill_way), 256'(e.way));
    checkOutput("fill_data", fill_data, data_of(e.addr));
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput("fill_valid_stall", 256'(fill_valid), 256'(1'b1));
      checkOutput("fill_data_stall", fill_data, data_of(e.addr));
      checkOutput("fill_address_stall", 256'(fill_address), 256'(e.addr));
      checkOutput("pf_read_stall", 256'(pf_read), 256'(1'b0));
    end
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    checkOutput("fill_valid_fall", 256'(fill_valid), 256'(1'b0));
  endtask

  // Directed sequence.
  initial begin
    rst        = 1'b1;
    trig_valid = 1'b0;
    trig_addr  = '0;
    trig_way   = '0;
    flush      = 1'b0;
    pf_rdata   = '0;
    pf_resp    = 1'b0;
    fill_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset_pf_read", 256'(pf_read), 256'(1'b0));
    checkOutput("reset_pf_address", 256'(pf_address), 256'(32'h0));
    checkOutput("reset_fill_valid", 256'(fill_valid), 256'(1'b0));
    checkOutput("reset_fill_data", fill_data, 256'(0));
    checkOutput("reset_fill_address", 256'(fill_address), 256'(32'h0));
    checkOutput("reset_fill_way", 256'(fill_way), 256'(1'b0));
    checkOutput("reset_busy", 256'(busy), 256'(1'b0));
    rst = 1'b0;
    tick();

    $display("[TB] basic two-line stream");
    expect_stream(32'h1020, 1'b1, 2);
    applyStimulus(32'h0000_1004, 1'b1);
    checkOutput("first_read_latency", 256'(pf_read), 256'(1'b1));
    do_read(0);
    do_fill(0);
    checkOutput("next_read_latency", 256'(pf_read), 256'(1'b1));
    do_read(1);
    do_fill(0);
    checkOutput("basic_idle_busy", 256'(busy), 256'(1'b0));

    $display("[TB] page boundary");
    expect_stream(32'h1FE0, 1'b0, 1);
    applyStimulus(32'h0000_1FC0, 1'b0);
    do_read(0);
    do_fill(0);
    checkOutput("page_one_line_busy", 256'(busy), 256'(1'b0));
    applyStimulus(32'h0000_1FE0, 1'b1);
    checkOutput("page_last_pf_read", 256'(pf_read), 256'(1'b0));
    checkOutput("page_last_busy", 256'(busy), 256'(1'b0));
    tick();
    checkOutput("page_last_pf_read_later", 256'(pf_read), 256'(1'b0));

    $display("[TB] duplicate filter and pending trigger");
    expect_stream(32'h1020, 1'b1, 2);
    expect_stream(32'h5020, 1'b0, 2);
    applyStimulus(32'h0000_1004, 1'b1);
    applyStimulus(32'h0000_1020, 1'b1);
    applyStimulus(32'h0000_5000, 1'b0);
    applyStimulus(32'h0000_1040, 1'b1);
    checkOutput("pending_busy", 256'(busy), 256'(1'b1));
    do_read(0);
    do_fill(0);
    do_read(0);
    do_fill(0);
    checkOutput("pending_gap_pf_read", 256'(pf_read), 256'(1'b0));
    checkOutput("pending_gap_busy", 256'(busy), 256'(1'b1));
    tick();
    checkOutput("pending_start", 256'(pf_read), 256'(1'b1));
    do_read(0);
    do_fill(0);
    do_read(0);
    do_fill(0);
    checkOutput("pending_done_busy", 256'(busy), 256'(1'b0));

    $display("[TB] flush during request");
    applyStimulus(32'h0000_1004, 1'b1);
    applyStimulus(32'h0000_5000, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("drain_pf_read", 256'(pf_read), 256'(1'b1));
    checkOutput("drain_pf_address", 256'(pf_address), 256'(32'h1020));
    checkOutput("drain_fill_valid", 256'(fill_valid), 256'(1'b0));
    tick();
    checkOutput("drain_pf_read_2", 256'(pf_read), 256'(1'b1));
    tick();
    checkOutput("drain_pf_read_3", 256'(pf_read), 256'(1'b1));
    pf_resp  = 1'b1;
    pf_rdata = data_of(32'h1020);
    tick();
    pf_resp  = 1'b0;
    pf_rdata = '0;
    checkOutput("drain_done_pf_read", 256'(pf_read), 256'(1'b0));
    checkOutput("drain_done_fill_valid", 256'(fill_valid), 256'(1'b0));
    checkOutput("drain_done_busy", 256'(busy), 256'(1'b0));
    tick();
    checkOutput("drain_no_pending", 256'(pf_read), 256'(1'b0));

    $display("[TB] fill back-pressure");
    expect_stream(32'h2020, 1'b0, 2);
    applyStimulus(32'h0000_2000, 1'b0);
    do_read(2);
    do_fill(5);
    checkOutput("stall_next_read", 256'(pf_read), 256'(1'b1));
    do_read(0);
    do_fill(0);
    checkOutput("stall_done_busy", 256'(busy), 256'(1'b0));

    $display("[TB] asynchronous reset mid-request");
    applyStimulus(32'h0000_3000, 1'b1);
    checkOutput("pre_reset_pf_read", 256'(pf_read), 256'(1'b1));
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_pf_read", 256'(pf_read), 256'(1'b0));
    checkOutput("async_pf_address", 256'(pf_address), 256'(32'h0));
    checkOutput("async_busy", 256'(busy), 256'(1'b0));
    checkOutput("async_fill_valid", 256'(fill_valid), 256'(1'b0));
    tick();
    rst      = 1'b0;
    pf_resp  = 1'b1;
    pf_rdata = data_of(32'h3020);
    tick();
    pf_resp  = 1'b0;
    pf_rdata = '0;
    checkOutput("late_resp_fill_valid", 256'(fill_valid), 256'(1'b0));
    checkOutput("late_resp_busy", 256'(busy), 256'(1'b0));
    tick();
    checkOutput("late_resp_pf_read", 256'(pf_read), 256'(1'b0));
    checkOutput("late_resp_fill_valid_2", 256'(fill_valid), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
